// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between
// NREQ requesters, each with its own valid/ready request and response channel.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_srcA,
    input  logic [NREQ*WIDTH-1:0] req_srcB,
    input  logic [NREQ*3-1:0]     req_ctrl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic [WIDTH-1:0]      alu_srcA,
    output logic [WIDTH-1:0]      alu_srcB,
    output logic [2:0]            alu_ctrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   last_grant;
    logic [IDXW-1:0]   grant;
    logic [IDXW-1:0]   pick;
    logic [IDXW-1:0]   idx;
    logic              pick_found;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [2:0]        sel_ctrl;

    // Walk the requesters starting just after the last winner, wrapping at NREQ-1.
    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = last_grant;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == IDXW'(NREQ - 1)) ? '0 : idx + IDXW'(1);
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IDXW'(i)) begin
                sel_a    = req_srcA[i*WIDTH +: WIDTH];
                sel_b    = req_srcB[i*WIDTH +: WIDTH];
                sel_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (pick_found && !reset) begin
                    req_ready = NREQ'(1) << pick;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = NREQ'(1) << grant;
                if (rsp_ready[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDXW'(NREQ - 1);
            grant      <= '0;
            alu_srcA   <= '0;
            alu_srcB   <= '0;
            alu_ctrl   <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                alu_srcA   <= sel_a;
                alu_srcB   <= sel_b;
                alu_ctrl   <= sel_ctrl;
                grant      <= pick;
                last_grant <= pick;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with three requesters, a behavioural
// ALU on the alu_* port, and a round-robin/transaction reference model.
module tb_alu_share_arbiter;

    localparam int W    = 32;
    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_srcA, req_srcB;
    logic [NREQ*3-1:0] req_ctrl;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;
    logic [W-1:0]      alu_srcA, alu_srcB, alu_result;
    logic [2:0]        alu_ctrl;
    logic              alu_zero;

    logic [W-1:0] fa [NREQ];
    logic [W-1:0] fb [NREQ];
    logic [2:0]   fc [NREQ];

    int n_cmp  = 0;
    int n_bad  = 0;
    int last_m = NREQ - 1;

    alu_share_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_srcA(req_srcA), .req_srcB(req_srcB), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // ALU semantics: 000 add, 001 sub, 010 and, 011 or, 100 signed slt, others 0.
    function automatic logic [W-1:0] alu_ref(input logic [2:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_ctrl, alu_srcA, alu_srcB);
        alu_zero   = (alu_result == '0);
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_srcA[i*W +: W] = fa[i];
            req_srcB[i*W +: W] = fb[i];
            req_ctrl[i*3 +: 3] = fc[i];
        end
    end

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First valid requester after the previous winner, counting modulo NREQ.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        fa[i] = a;
        fb[i] = b;
        fc[i] = c;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
        check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(0));
        check({tag, "_alu_srcA"}, 64'(alu_srcA), 64'(0));
        check({tag, "_alu_srcB"}, 64'(alu_srcB), 64'(0));
        check({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'(0));
    endtask

    // Holds reset for two cycles with all requesters valid; ready must stay low.
    task automatic do_reset(input string tag);
        reset     = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        @(posedge clk) #1;
        check_reset_values(tag);
        @(posedge clk) #1;
        check({tag, "_ready_held"}, 64'(req_ready), 64'(0));
        reset     = 1'b0;
        req_valid = '0;
        last_m    = NREQ - 1;
    endtask

    // Runs one full transaction from the current IDLE cycle. hold = cycles the
    // granted response is back-pressured; rnd = re-randomise requests mid-flight.
    task automatic run_op(input string tag, input int hold, input bit rnd);
        int g;
        logic [W-1:0] a, b, r;
        logic [2:0] c;
        #1;
        g = rr_pick(last_m, req_valid);
        if (g < 0) begin
            check({tag, "_idle_ready"}, 64'(req_ready), 64'(0));
            check({tag, "_idle_rsp"}, 64'(rsp_valid), 64'(0));
            @(posedge clk) #1;
            return;
        end
        a = fa[g];
        b = fb[g];
        c = fc[g];
        r = alu_ref(c, a, b);
        check({tag, "_grant"}, 64'(req_ready), 64'(onehot(g)));
        rsp_ready = (hold == 0) ? '1 : ~onehot(g);
        @(posedge clk) #1;
        last_m = g;
        check({tag, "_exec_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_exec_rsp"}, 64'(rsp_valid), 64'(0));
        check({tag, "_alu_srcA"}, 64'(alu_srcA), 64'(a));
        check({tag, "_alu_srcB"}, 64'(alu_srcB), 64'(b));
        check({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'(c));
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == g || !req_valid[i]) begin
                    set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
                    if ($urandom_range(0, 3) == 0) fb[i] = fa[i];
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        @(posedge clk) #1;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(posedge clk) #1;
            check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(onehot(g)));
            check({tag, "_rsp_result"}, 64'(rsp_result), 64'(r));
            check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(r == '0));
            check({tag, "_rsp_ready_lo"}, 64'(req_ready), 64'(0));
        end
        rsp_ready = onehot(g);
        @(posedge clk) #1;
        check({tag, "_rsp_done"}, 64'(rsp_valid), 64'(0));
        rsp_ready = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'b000, '0, '0);
        @(posedge clk) #1;
        do_reset("rst0");

        // Single op with immediate consume, then an idle cycle.
        set_req(0, 3'b000, 32'd5, 32'd3);
        req_valid = 3'b001;
        run_op("single", 0, 1'b0);
        req_valid = '0;
        run_op("single_idle", 0, 1'b0);

        // Round-robin between two persistently valid requesters.
        do_reset("rst_rr");
        set_req(0, 3'b001, 32'd7, 32'd7);
        set_req(1, 3'b011, 32'h0F, 32'hF0);
        req_valid = 3'b011;
        for (int n = 0; n < 4; n++) run_op("rr", 0, 1'b0);

        // Back-pressured SLT with stray rsp_ready on the other bits.
        set_req(1, 3'b100, 32'hFFFF_FFFF, 32'd1);
        req_valid = 3'b010;
        run_op("bp", 5, 1'b0);

        // Undefined op code must yield result 0, zero 1.
        set_req(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
        req_valid = 3'b001;
        run_op("illegal", 0, 1'b0);

        // Reset arriving during EXEC of a req0 operation.
        set_req(0, 3'b000, 32'd100, 32'd23);
        req_valid = 3'b001;
        #1;
        check("mid_grant", 64'(req_ready), 64'(onehot(rr_pick(last_m, req_valid))));
        @(posedge clk) #1;
        reset     = 1'b1;
        req_valid = 3'b011;
        @(posedge clk) #1;
        check_reset_values("mid_rst");
        reset  = 1'b0;
        last_m = NREQ - 1;
        run_op("after_rst", 0, 1'b0);

        // Wrap-around: lone req2, then req0 and req1 together.
        do_reset("rst_wrap");
        set_req(2, 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF);
        req_valid = 3'b100;
        run_op("wrap_r2", 0, 1'b0);
        set_req(0, 3'b000, 32'hFFFF_FFFF, 32'd1);
        set_req(1, 3'b001, 32'd3, 32'd10);
        req_valid = 3'b011;
        run_op("wrap_r0", 0, 1'b0);
        run_op("wrap_r1", 0, 1'b0);

        // Random traffic with drop-outs and back-pressure.
        for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
        req_valid = 3'($urandom_range(1, 7));
        for (int n = 0; n < 200; n++) run_op("rand", int'($urandom_range(0, 3)), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
